branch_conditional_unit: RTL

- Consumer end of the decode-stage-2 B-form output interface. Accepts decoded Branch Conditional micro-ops (decoded opcode 24) and evaluates the BO/BI condition against CR and CTR.
- Computes the branch target and owns the architectural CTR and LR registers.
- Emits a registered branch-resolution record to fetch/completion.
- Sits in the BranchUnitID (6) execution slot.

---
 rtl/branch_conditional_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_conditional_unit.sv
// Branch Conditional execution unit: evaluates BO/BI against CR and CTR, computes
// the redirect address, owns CTR/LR and emits a registered resolution record.
module branch_conditional_unit #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int bodyWidth               = 28,
    parameter int BCOpcode                = 24
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [bodyWidth-1:0]               instructionBody_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth:0]   instMajId_i,
    input  logic [instMinIdWidth-1:0]          instMinId_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic [31:0]                        cr_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic                               ctrWrite_i,
    input  logic                               lrWrite_i,
    input  logic [63:0]                        sprData_i,
    output logic                               ready_o,
    output logic                               valid_o,
    output logic                               taken_o,
    output logic [addressWidth-1:0]            target_o,
    output logic [instructionCounterWidth:0]   instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic                               illegal_o,
    output logic [63:0]                        ctr_o,
    output logic [63:0]                        lr_o
);

    // Body uses big-endian bit numbering: ISA bit i lives at instructionBody_i[bodyWidth-1-i].
    logic        bo_ignore_cond;
    logic        bo_cond_val;
    logic        bo_no_dec;
    logic        bo_ctr_val;
    logic        unused_hint;
    logic [4:0]  bi;
    logic [15:0] bd_ext;
    logic        aa;
    logic        lk;

    assign bo_ignore_cond = instructionBody_i[bodyWidth-1];
    assign bo_cond_val    = instructionBody_i[bodyWidth-2];
    assign bo_no_dec      = instructionBody_i[bodyWidth-3];
    assign bo_ctr_val     = instructionBody_i[bodyWidth-4];
    assign unused_hint    = instructionBody_i[bodyWidth-5];
    assign bi             = instructionBody_i[bodyWidth-6 -: 5];
    assign bd_ext         = instructionBody_i[bodyWidth-11 -: 16];
    assign aa             = instructionBody_i[1];
    assign lk             = instructionBody_i[0];

    logic [63:0] ctr_q;
    logic [63:0] lr_q;
    logic [63:0] ctr_next;
    logic        ctr_zero;
    logic        ctr_ok;
    logic        cond_ok;
    logic        taken;
    logic [63:0] addr64;
    logic [63:0] disp;
    logic [63:0] mode_mask;
    logic [63:0] tgt;
    logic [63:0] seq;
    logic        op_match;
    logic        issue;
    logic        accept;
    logic        reject;

    assign ready_o  = !valid_o || !stall_i;
    assign op_match = (opcode_i == opcodeSize'(BCOpcode));
    assign issue    = enable_i && ready_o && !flush_i;
    assign accept   = issue && op_match;
    assign reject   = issue && !op_match;

    assign ctr_next = bo_no_dec ? ctr_q : ctr_q - 64'd1;
    assign ctr_zero = is64Bit_i ? (ctr_next == 64'd0) : (ctr_next[31:0] == 32'd0);
    assign ctr_ok   = bo_no_dec || (ctr_zero == bo_ctr_val);
    assign cond_ok  = bo_ignore_cond || (cr_i[5'd31 - bi] == bo_cond_val);
    assign taken    = ctr_ok && cond_ok;

    // 32-bit mode clears the upper word of every address produced here, including LR.
    assign addr64    = 64'(instructionAddress_i);
    assign disp      = {{48{bd_ext[15]}}, bd_ext};
    assign mode_mask = is64Bit_i ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    assign tgt       = (aa ? disp : addr64 + disp) & mode_mask;
    assign seq       = (addr64 + 64'd4) & mode_mask;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o     <= 1'b0;
            taken_o     <= 1'b0;
            target_o    <= '0;
            instMajId_o <= '0;
            instMinId_o <= '0;
            instPid_o   <= '0;
            instTid_o   <= '0;
            illegal_o   <= 1'b0;
        end else begin
            illegal_o <= reject;
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (accept) begin
                valid_o     <= 1'b1;
                taken_o     <= taken;
                target_o    <= addressWidth'(taken ? tgt : seq);
                instMajId_o <= instMajId_i;
                instMinId_o <= instMinId_i;
                instPid_o   <= instPid_i;
                instTid_o   <= instTid_i;
            end else if (!stall_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    // A branch's own CTR/LR update wins over an mtspr landing on the same edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_q <= 64'd0;
            lr_q  <= 64'd0;
        end else begin
            if (accept && !bo_no_dec) begin
                ctr_q <= ctr_next;
            end else if (ctrWrite_i) begin
                ctr_q <= sprData_i;
            end
            if (accept && lk) begin
                lr_q <= seq;
            end else if (lrWrite_i) begin
                lr_q <= sprData_i;
            end
        end
    end

    assign ctr_o = ctr_q;
    assign lr_o  = lr_q;

endmodule
